// File: rtl/mips_pipe_pkg.sv
// Shared widths and opcodes for the MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
package mips_pipe_pkg;

   localparam int         PIPE_DATA_W = 32;
   localparam int         PIPE_REG_AW = 5;
   localparam int         PIPE_OP_W   = 6;
   localparam int         PIPE_CNT_W  = 16;
   localparam logic [5:0] PIPE_LW_OP  = 6'h23;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags when the ID instruction reads the
// destination of a load that is currently sitting in EX.
module load_use_detect #(
   parameter int              REG_AW = 5,
   parameter int              OP_W   = 6,
   parameter logic [OP_W-1:0] LW_OP  = 6'h23
) (
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rt_used,
   input  logic              ex_valid,
   input  logic              ex_regwrite,
   input  logic [OP_W-1:0]   ex_op,
   input  logic [REG_AW-1:0] ex_wreg,
   output logic              hazard
);

   logic ex_is_load;
   logic rs_match;
   logic rt_match;

   // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
   always_comb begin
      ex_is_load = ex_valid && ex_regwrite && (ex_op == LW_OP) && (ex_wreg != '0);
      rs_match   = (ex_wreg == id_rs);
      rt_match   = id_rt_used && (ex_wreg == id_rt);
      hazard     = id_valid && ex_is_load && (rs_match || rt_match);
   end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush/stall control, load-use bubble
// insertion and a saturating bubble counter. State updates on the falling edge.
module id_ex_pipe_reg
   import mips_pipe_pkg::*;
#(
   parameter int              DATA_W = PIPE_DATA_W,
   parameter int              REG_AW = PIPE_REG_AW,
   parameter int              OP_W   = PIPE_OP_W,
   parameter logic [OP_W-1:0] LW_OP  = OP_W'(PIPE_LW_OP),
   parameter int              CNT_W  = PIPE_CNT_W
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [DATA_W-1:0] next_PC_in,
   input  logic [DATA_W-1:0] Rdata1_in,
   input  logic [DATA_W-1:0] Rdata2_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [OP_W-1:0]   OP_in,
   input  logic [OP_W-1:0]   Funct_in,
   input  logic [REG_AW-1:0] Wreg_addr_in,
   input  logic [REG_AW-1:0] rs_in,
   input  logic [REG_AW-1:0] rt_in,
   input  logic              RegWrite_in,
   input  logic              rt_used_in,
   input  logic              valid_in,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] next_PC_out,
   output logic [DATA_W-1:0] Rdata1_out,
   output logic [DATA_W-1:0] Rdata2_out,
   output logic [DATA_W-1:0] imm_out,
   output logic [OP_W-1:0]   OP_out,
   output logic [OP_W-1:0]   Funct_out,
   output logic [REG_AW-1:0] Wreg_addr_out,
   output logic              RegWrite_out,
   output logic              valid_out,
   output logic              hazard_stall,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic [DATA_W-1:0] next_pc_q, next_pc_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [DATA_W-1:0] rdata2_q, rdata2_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [OP_W-1:0]   funct_q, funct_d;
   logic [REG_AW-1:0] wreg_q, wreg_d;
   logic              regwrite_q, regwrite_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  bubble_q, bubble_d;
   logic              hazard;
   logic              bubble_evt;

   load_use_detect #(
      .REG_AW (REG_AW),
      .OP_W   (OP_W),
      .LW_OP  (LW_OP)
   ) u_load_use_detect (
      .id_valid    (valid_in),
      .id_rs       (rs_in),
      .id_rt       (rt_in),
      .id_rt_used  (rt_used_in),
      .ex_valid    (valid_q),
      .ex_regwrite (regwrite_q),
      .ex_op       (op_q),
      .ex_wreg     (wreg_q),
      .hazard      (hazard)
   );

   // Hold request to IF/ID; suppressed when this stage is itself flushed or held.
   always_comb begin
      hazard_stall = hazard && !flush && !stall;
   end

   // Next-state selection: flush > stall > hazard bubble > normal load.
   always_comb begin
      next_pc_d  = next_pc_q;
      rdata1_d   = rdata1_q;
      rdata2_d   = rdata2_q;
      imm_d      = imm_q;
      op_d       = op_q;
      funct_d    = funct_q;
      wreg_d     = wreg_q;
      regwrite_d = regwrite_q;
      valid_d    = valid_q;
      bubble_evt = 1'b0;
      if (flush || (!stall && hazard)) begin
         next_pc_d  = '0;
         rdata1_d   = '0;
         rdata2_d   = '0;
         imm_d      = '0;
         op_d       = '0;
         funct_d    = '0;
         wreg_d     = '0;
         regwrite_d = 1'b0;
         valid_d    = 1'b0;
         bubble_evt = 1'b1;
      end else if (!stall) begin
         next_pc_d  = next_PC_in;
         rdata1_d   = Rdata1_in;
         rdata2_d   = Rdata2_in;
         imm_d      = imm_in;
         op_d       = OP_in;
         funct_d    = Funct_in;
         wreg_d     = Wreg_addr_in;
         regwrite_d = RegWrite_in && valid_in;
         valid_d    = valid_in;
      end
   end

   // Bubble counter saturates rather than wrapping.
   always_comb begin
      bubble_d = bubble_q;
      if (bubble_evt && (bubble_q != {CNT_W{1'b1}})) begin
         bubble_d = bubble_q + CNT_W'(1);
      end
   end

   // Pipeline register bank, updated on the falling edge.
   always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         next_pc_q  <= '0;
         rdata1_q   <= '0;
         rdata2_q   <= '0;
         imm_q      <= '0;
         op_q       <= '0;
         funct_q    <= '0;
         wreg_q     <= '0;
         regwrite_q <= 1'b0;
         valid_q    <= 1'b0;
         bubble_q   <= '0;
      end else begin
         next_pc_q  <= next_pc_d;
         rdata1_q   <= rdata1_d;
         rdata2_q   <= rdata2_d;
         imm_q      <= imm_d;
         op_q       <= op_d;
         funct_q    <= funct_d;
         wreg_q     <= wreg_d;
         regwrite_q <= regwrite_d;
         valid_q    <= valid_d;
         bubble_q   <= bubble_d;
      end
   end

   assign next_PC_out   = next_pc_q;
   assign Rdata1_out    = rdata1_q;
   assign Rdata2_out    = rdata2_q;
   assign imm_out       = imm_q;
   assign OP_out        = op_q;
   assign Funct_out     = funct_q;
   assign Wreg_addr_out = wreg_q;
   assign RegWrite_out  = regwrite_q;
   assign valid_out     = valid_q;
   assign bubble_cnt    = bubble_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg; a second instance with a 2-bit counter checks saturation.
module tb_id_ex_pipe_reg;

   logic        CLK = 1'b1;
   logic        RST_N;
   logic [31:0] next_PC_in, Rdata1_in, Rdata2_in, imm_in;
   logic [5:0]  OP_in, Funct_in;
   logic [4:0]  Wreg_addr_in, rs_in, rt_in;
   logic        RegWrite_in, rt_used_in, valid_in, stall, flush;

   logic [31:0] next_PC_out, Rdata1_out, Rdata2_out, imm_out;
   logic [5:0]  OP_out, Funct_out;
   logic [4:0]  Wreg_addr_out;
   logic        RegWrite_out, valid_out, hazard_stall;
   logic [15:0] bubble_cnt;

   logic [31:0] s_next_PC_out, s_Rdata1_out, s_Rdata2_out, s_imm_out;
   logic [5:0]  s_OP_out, s_Funct_out;
   logic [4:0]  s_Wreg_addr_out;
   logic        s_RegWrite_out, s_valid_out, s_hazard_stall;
   logic [1:0]  s_bubble_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   id_ex_pipe_reg dut (
      .CLK(CLK), .RST_N(RST_N),
      .next_PC_in(next_PC_in), .Rdata1_in(Rdata1_in), .Rdata2_in(Rdata2_in), .imm_in(imm_in),
      .OP_in(OP_in), .Funct_in(Funct_in), .Wreg_addr_in(Wreg_addr_in), .rs_in(rs_in), .rt_in(rt_in),
      .RegWrite_in(RegWrite_in), .rt_used_in(rt_used_in), .valid_in(valid_in),
      .stall(stall), .flush(flush),
      .next_PC_out(next_PC_out), .Rdata1_out(Rdata1_out), .Rdata2_out(Rdata2_out), .imm_out(imm_out),
      .OP_out(OP_out), .Funct_out(Funct_out), .Wreg_addr_out(Wreg_addr_out),
      .RegWrite_out(RegWrite_out), .valid_out(valid_out),
      .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
   );

   id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
      .CLK(CLK), .RST_N(RST_N),
      .next_PC_in(next_PC_in), .Rdata1_in(Rdata1_in), .Rdata2_in(Rdata2_in), .imm_in(imm_in),
      .OP_in(OP_in), .Funct_in(Funct_in), .Wreg_addr_in(Wreg_addr_in), .rs_in(rs_in), .rt_in(rt_in),
      .RegWrite_in(RegWrite_in), .rt_used_in(rt_used_in), .valid_in(valid_in),
      .stall(stall), .flush(flush),
      .next_PC_out(s_next_PC_out), .Rdata1_out(s_Rdata1_out), .Rdata2_out(s_Rdata2_out), .imm_out(s_imm_out),
      .OP_out(s_OP_out), .Funct_out(s_Funct_out), .Wreg_addr_out(s_Wreg_addr_out),
      .RegWrite_out(s_RegWrite_out), .valid_out(s_valid_out),
      .hazard_stall(s_hazard_stall), .bubble_cnt(s_bubble_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic set_id(input logic [31:0] pc, input logic [31:0] r1, input logic [5:0] op,
                         input logic [4:0] wreg, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rw, input logic rtu, input logic vld);
      next_PC_in   = pc;
      Rdata1_in    = r1;
      Rdata2_in    = ~r1;
      imm_in       = {16'h0, pc[15:0]};
      OP_in        = op;
      Funct_in     = 6'h20;
      Wreg_addr_in = wreg;
      rs_in        = rs;
      rt_in        = rt;
      RegWrite_in  = rw;
      rt_used_in   = rtu;
      valid_in     = vld;
   endtask

   initial begin
      RST_N = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      set_id(32'h0, 32'h0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("rst_valid",   valid_out, 0);
      chk("rst_rdata1",  Rdata1_out, 0);
      chk("rst_bubble",  bubble_cnt, 0);
      chk("rst_hazard",  hazard_stall, 0);
      RST_N = 1'b1;

      // normal load
      set_id(32'h100, 32'h1234_5678, 6'h00, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      #1;
      chk("load_pre_hazard", hazard_stall, 0);
      tick();
      chk("load_rdata1",   Rdata1_out, 32'h1234_5678);
      chk("load_valid",    valid_out, 1);
      chk("load_regwrite", RegWrite_out, 1);
      chk("load_pc",       next_PC_out, 32'h100);
      chk("load_rdata2",   Rdata2_out, 32'hEDCB_A987);
      chk("load_imm",      imm_out, 32'h100);
      chk("load_funct",    Funct_out, 6'h20);
      chk("load_wreg",     Wreg_addr_out, 5'd3);

      // async reset between edges
      RST_N = 1'b0;
      #1;
      chk("arst_rdata1", Rdata1_out, 0);
      chk("arst_valid",  valid_out, 0);
      chk("arst_wreg",   Wreg_addr_out, 0);
      #1;
      RST_N = 1'b1;
      tick();
      chk("post_rst_load", valid_out, 1);

      // load-use on rs
      set_id(32'h104, 32'h1000, 6'h23, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      #1;
      chk("lw_no_hazard", hazard_stall, 0);
      tick();
      chk("lw_op",   OP_out, 6'h23);
      chk("lw_wreg", Wreg_addr_out, 5'd8);
      set_id(32'h108, 32'hAAAA, 6'h00, 5'd9, 5'd8, 5'd4, 1'b1, 1'b1, 1'b1);
      #1;
      chk("use_hazard", hazard_stall, 1);
      tick();
      chk("bub_valid",    valid_out, 0);
      chk("bub_regwrite", RegWrite_out, 0);
      chk("bub_wreg",     Wreg_addr_out, 0);
      chk("bub_op",       OP_out, 0);
      chk("bub_rdata1",   Rdata1_out, 0);
      chk("bub_cnt",      bubble_cnt, 1);
      chk("bub_hz_clear", hazard_stall, 0);
      tick();
      chk("after_bub_valid",  valid_out, 1);
      chk("after_bub_rdata1", Rdata1_out, 32'hAAAA);
      chk("after_bub_wreg",   Wreg_addr_out, 5'd9);
      chk("after_bub_cnt",    bubble_cnt, 1);

      // rt match only counts when rt is used
      set_id(32'h10C, 32'h2000, 6'h23, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      tick();
      set_id(32'h110, 32'hBBBB, 6'h00, 5'd10, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1);
      #1;
      chk("rt_unused_hz", hazard_stall, 0);
      rt_used_in = 1'b1;
      #1;
      chk("rt_used_hz", hazard_stall, 1);
      rt_used_in = 1'b0;
      tick();
      chk("rt_unused_valid",  valid_out, 1);
      chk("rt_unused_rdata1", Rdata1_out, 32'hBBBB);
      chk("rt_unused_cnt",    bubble_cnt, 1);

      // load to r0 never hazards
      set_id(32'h114, 32'h3000, 6'h23, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      tick();
      set_id(32'h118, 32'hCCCC, 6'h00, 5'd11, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      #1;
      chk("r0_hz", hazard_stall, 0);
      tick();
      chk("r0_valid",  valid_out, 1);
      chk("r0_rdata1", Rdata1_out, 32'hCCCC);

      // RegWrite gated by valid_in
      set_id(32'h11C, 32'hDDDD, 6'h00, 5'd12, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("inv_valid",    valid_out, 0);
      chk("inv_regwrite", RegWrite_out, 0);
      chk("inv_rdata1",   Rdata1_out, 32'hDDDD);

      // stall holds for 3 edges, hazard suppressed during stall
      set_id(32'h120, 32'hEEEE, 6'h23, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      tick();
      chk("x_valid", valid_out, 1);
      stall = 1'b1;
      set_id(32'h124, 32'h1111, 6'h00, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
      #1;
      chk("stall_hz_masked", hazard_stall, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_rdata1", Rdata1_out, 32'hEEEE);
         chk("stall_wreg",   Wreg_addr_out, 5'd5);
         chk("stall_valid",  valid_out, 1);
      end
      chk("stall_cnt", bubble_cnt, 1);
      flush = 1'b1;
      #1;
      chk("flush_hz_masked", hazard_stall, 0);
      tick();
      chk("sf_valid",    valid_out, 0);
      chk("sf_regwrite", RegWrite_out, 0);
      chk("sf_rdata1",   Rdata1_out, 0);
      chk("sf_op",       OP_out, 0);
      chk("sf_cnt",      bubble_cnt, 2);
      flush = 1'b0;
      stall = 1'b0;

      // reset during stall discards held instruction
      set_id(32'h128, 32'h2222, 6'h00, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      tick();
      chk("y_rdata1", Rdata1_out, 32'h2222);
      stall = 1'b1;
      Rdata1_in = 32'h3333;
      RST_N = 1'b0;
      #1;
      chk("rst_stall_valid", valid_out, 0);
      chk("rst_stall_cnt",   bubble_cnt, 0);
      RST_N = 1'b1;
      stall = 1'b0;
      tick();
      chk("rst_stall_load",  Rdata1_out, 32'h3333);
      chk("rst_stall_vld",   valid_out, 1);

      // saturation with 2-bit counter
      valid_in = 1'b0;
      flush = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 2) begin
            chk("sat_cnt3",  s_bubble_cnt, 2'b11);
            chk("main_cnt3", bubble_cnt, 3);
         end
      end
      chk("sat_cnt5",  s_bubble_cnt, 2'b11);
      chk("main_cnt5", bubble_cnt, 5);
      chk("sat_valid", s_valid_out, 0);
      flush = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of PC, register-data and immediate fields.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter OP_W, default 6, width of OP and Funct fields.
REQ-004 SHALL have parameter LW_OP, default 6'h23, opcode treated as a load for hazard detection.
REQ-005 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-006 SHALL have port CLK  input  1  single clock; all state updates on falling edge of CLK.
REQ-007 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports next_PC_in, Rdata1_in, Rdata2_in, imm_in  input  DATA_W each  ID-stage operands.
REQ-009 SHALL have ports OP_in, Funct_in  input  OP_W each; Wreg_addr_in, rs_in, rt_in  input  REG_AW each.
REQ-010 SHALL have ports RegWrite_in, rt_used_in, valid_in  input  1 each; valid_in marks a real instruction.
REQ-011 SHALL have ports stall  input  1  downstream hold; flush  input  1  branch/jump squash.
REQ-012 SHALL have registered outputs next_PC_out, Rdata1_out, Rdata2_out, imm_out, OP_out, Funct_out, Wreg_addr_out, RegWrite_out, valid_out, widths matching inputs.
REQ-013 SHALL have output hazard_stall  1  combinational request to hold PC and IF/ID register.
REQ-014 SHALL have output bubble_cnt  CNT_W  count of bubbles inserted.

Function
REQ-015 hazard condition SHALL be: valid_in & valid_out & RegWrite_out & (OP_out==LW_OP) & (Wreg_addr_out!=0) & ((Wreg_addr_out==rs_in) | (rt_used_in & Wreg_addr_out==rt_in)).
REQ-016 hazard_stall SHALL equal hazard condition & ~flush & ~stall, purely combinational, no added latency.
REQ-017 per falling edge, priority SHALL be flush > stall > hazard > load.
REQ-018 flush: all outputs SHALL be cleared to zero (valid_out=0, RegWrite_out=0); asserted with stall, flush wins.
REQ-019 stall (no flush): all output registers SHALL hold their values; bubble_cnt unchanged.
REQ-020 hazard (no flush/stall): bubble inserted -- all output fields zero, valid_out=0, RegWrite_out=0.
REQ-021 load (none of above): every output register SHALL capture its input one falling edge later; RegWrite_out SHALL equal RegWrite_in & valid_in.
REQ-022 a load-use hazard SHALL cost exactly one bubble: after insertion valid_out=0 so the condition clears next cycle.
REQ-023 bubble_cnt SHALL increment by 1 on each edge where flush or a hazard bubble takes effect, saturating at all-ones (no wrap).
REQ-024 register 0 as destination SHALL never raise hazard_stall.

Reset
REQ-025 RST_N low SHALL immediately, independent of CLK, clear every output register and bubble_cnt to zero.
REQ-026 reset asserted mid-stall or mid-hazard SHALL discard the held/pending instruction; first edge after release performs a normal load if no stall/flush/hazard.
REQ-027 hazard_stall SHALL be 0 while RST_N low (valid_out is 0).

Structure
REQ-028 DATA_W, REG_AW, OP_W defaults and LW_OP SHALL live in shared package mips_pipe_pkg, reused by IF/ID, EX/MEM and MEM/WB registers.
REQ-029 hazard comparator SHALL be a separate sub-module load_use_detect (pure combinational); register bank and counter stay in id_ex_pipe_reg.

Verification
REQ-030 reset: drive RST_N=0 between edges -> all outputs 0 at once, bubble_cnt=0.
REQ-031 load: valid_in=1, OP_in=6'h00, Rdata1_in=32'h1234_5678, RegWrite_in=1 -> next falling edge Rdata1_out=32'h1234_5678, valid_out=1, RegWrite_out=1.
REQ-032 load-use: EX holds OP=6'h23, Wreg_addr=5'd8, RegWrite=1; ID rs_in=5'd8 -> hazard_stall=1, next edge valid_out=0, bubble_cnt=1, hazard_stall=0 after.
REQ-033 rt-only match with rt_used_in=0 and Wreg_addr_out=5'd0 case -> hazard_stall=0, normal load.
REQ-034 stall+flush same edge with valid EX contents -> outputs cleared, bubble_cnt+1; stall alone 3 edges -> outputs unchanged.
REQ-035 saturation: CNT_W=2, force 5 flushes -> bubble_cnt=2'b11, holds.
